// File: rtl/enemy_fire_scheduler.sv
// Enemy fire scheduler: every PERIOD cycles picks a pseudo-random column and fires from its lowest
// live enemy. Define ENEMY_FIRE_SPEEDUP_EN to halve the interval once few enemies remain.
module enemy_fire_scheduler #(
   parameter int unsigned COLUMNS = 13,
   parameter int unsigned ROWS    = 5,
   parameter logic [23:0] PERIOD  = 24'd10000000,
   parameter logic [15:0] SEED    = 16'hACE1,
   localparam int unsigned CW     = $clog2(COLUMNS),
   localparam int unsigned RW     = $clog2(ROWS)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [ROWS*COLUMNS-1:0] alive,
   input  logic                    shot_busy,
   output logic                    fire,
   output logic [CW-1:0]           shooter_col,
   output logic [RW-1:0]           shooter_row
);

   localparam int unsigned N   = ROWS * COLUMNS;
   localparam int unsigned IW  = $clog2(N);
   localparam int unsigned CW1 = CW + 1;
   localparam logic [CW-1:0] ColLast = CW'(COLUMNS - 1);
   localparam logic [RW-1:0] RowLast = RW'(ROWS - 1);
   localparam logic [CW:0]   ColsW   = CW1'(COLUMNS);

   typedef enum logic [2:0] {StWait, StPick, StScan, StFire, StHold} state_e;

   state_e        state_q;
   logic [23:0]   cnt_q;
   logic [15:0]   lfsr_q;
   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic [CW-1:0] att_q;
   logic          fire_q;
   logic [CW-1:0] shooter_col_q;
   logic [RW-1:0] shooter_row_q;

   logic [15:0]   lfsr_next;
   logic [CW-1:0] pick_col;
   logic [CW-1:0] col_inc;
   logic [IW-1:0] idx;
   logic          cell_alive;
   logic [23:0]   wait_last;

   assign lfsr_next  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
   // Low LFSR bits span less than 2*COLUMNS, so one conditional subtract reduces them.
   assign pick_col   = ({1'b0, lfsr_q[CW-1:0]} < ColsW) ? lfsr_q[CW-1:0]
                                                       : lfsr_q[CW-1:0] - ColsW[CW-1:0];
   assign col_inc    = (col_q == ColLast) ? '0 : col_q + 1'b1;
   assign idx        = IW'(row_q) * IW'(COLUMNS) + IW'(col_q);
   assign cell_alive = alive[idx];

`ifdef ENEMY_FIRE_SPEEDUP_EN
   localparam int unsigned PW = $clog2(N + 1);
   logic [PW-1:0] pop;

   always_comb begin
      pop = '0;
      for (int i = 0; i < N; i++) pop = pop + PW'(alive[i]);
      wait_last = (pop <= PW'(N / 4)) ? (PERIOD >> 1) - 24'd1 : PERIOD - 24'd1;
   end
`else
   assign wait_last = PERIOD - 24'd1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StWait;
         cnt_q         <= '0;
         lfsr_q        <= SEED;
         col_q         <= '0;
         row_q         <= '0;
         att_q         <= '0;
         fire_q        <= 1'b0;
         shooter_col_q <= '0;
         shooter_row_q <= '0;
      end else begin
         fire_q <= 1'b0;
         if (enable) begin
            lfsr_q <= lfsr_next;
            unique case (state_q)
               StWait: begin
                  // >= so a threshold drop below the running count still ends the wait
                  if (cnt_q >= wait_last) begin
                     cnt_q   <= '0;
                     state_q <= StPick;
                  end else begin
                     cnt_q <= cnt_q + 24'd1;
                  end
               end
               StPick: begin
                  col_q   <= pick_col;
                  row_q   <= RowLast;
                  att_q   <= '0;
                  state_q <= StScan;
               end
               StScan: begin
                  if (cell_alive) begin
                     state_q <= StFire;
                  end else if (row_q == '0) begin
                     if (att_q == ColLast) begin
                        state_q <= StWait;
                     end else begin
                        col_q <= col_inc;
                        row_q <= RowLast;
                        att_q <= att_q + 1'b1;
                     end
                  end else begin
                     row_q <= row_q - 1'b1;
                  end
               end
               StFire: begin
                  if (shot_busy) begin
                     state_q <= StHold;
                  end else begin
                     fire_q        <= 1'b1;
                     shooter_col_q <= col_q;
                     shooter_row_q <= row_q;
                     state_q       <= StWait;
                  end
               end
               StHold: begin
                  if (!shot_busy) state_q <= cell_alive ? StFire : StPick;
               end
               default: state_q <= StWait;
            endcase
         end
      end
   end

   // Gating keeps the pulse off whenever the game is paused or a shot is still in flight.
   assign fire        = fire_q & enable & ~shot_busy;
   assign shooter_col = shooter_col_q;
   assign shooter_row = shooter_row_q;

endmodule

// File: doc/enemy_fire_scheduler.md
ENEMY_FIRE_SCHEDULER -- requirements
Module: enemy_fire_scheduler

Interface
REQ-001 Parameter COLUMNS, default 13: enemy columns; SHALL satisfy 2^(CW-1) < COLUMNS <= 2^CW, where CW = $clog2(COLUMNS).
REQ-002 Parameter ROWS, default 5: enemy rows, row 0 at the top; RW = $clog2(ROWS).
REQ-003 Parameter PERIOD, default 24'd10000000: clk cycles between fire attempts; minimum 4.
REQ-004 Parameter SEED, default 16'hACE1: LFSR reset value; must be nonzero.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  high while the game is running; low freezes the scheduler.
REQ-008 alive  input  ROWS*COLUMNS  enemy alive bitmap; index = row*COLUMNS + col.
REQ-009 shot_busy  input  1  high while an enemy projectile is already in flight.
REQ-010 fire  output  1  one-cycle pulse; the shooter outputs are valid on this cycle.
REQ-011 shooter_col  output  CW  column of the selected shooter; held until the next fire.
REQ-012 shooter_row  output  RW  row of the selected shooter; held until the next fire.

Function
REQ-013 The LFSR SHALL be a 16-bit Galois LFSR with taps 0xB400, advancing every clk while enable=1.
REQ-014 The FSM SHALL have the states WAIT, PICK, SCAN, FIRE and HOLD.
REQ-015 WAIT: the interval counter counts up to PERIOD-1, then the FSM goes to PICK and clears the counter.
REQ-016 PICK (1 cycle): candidate column = lfsr[CW-1:0] if < COLUMNS, else lfsr[CW-1:0] - COLUMNS; the attempt counter is cleared; the row pointer is set to ROWS-1; next state SCAN.
REQ-017 SCAN: one row is tested per cycle, from the bottom up. If alive[row*COLUMNS+col] is 1, the row and column are latched and the FSM goes to FIRE.
REQ-018 SCAN, column exhausted (row 0 dead): col advances to (col+1) mod COLUMNS, the row resets to ROWS-1, and the attempt counter increments.
REQ-019 SCAN, COLUMNS columns tried with no alive enemy: the FSM returns to WAIT with no fire and the outputs unchanged.
REQ-020 Worst-case PICK-to-FIRE latency SHALL be 1 + ROWS*COLUMNS cycles.
REQ-021 FIRE, shot_busy=0: fire=1 for exactly one cycle, shooter_col/row are updated on that same cycle, then the FSM goes to WAIT.
REQ-022 FIRE, shot_busy=1: the FSM goes to HOLD with no fire.
REQ-023 HOLD: the FSM waits until shot_busy=0, re-checks the latched enemy's alive bit, and then:
  - alive: FIRE next cycle;
  - dead: PICK.
REQ-024 alive bits SHALL be sampled live each SCAN cycle; a kill during SCAN affects only rows not yet tested.
REQ-025 enable=0: the FSM state, counters and LFSR all hold, and fire=0; the scheduler resumes in place when enable returns high.
REQ-026 fire SHALL never assert while enable=0, while shot_busy=1, or on two consecutive cycles.

Reset
REQ-027 Reset SHALL drive:
  - state = WAIT;
  - interval counter = 0;
  - lfsr = SEED;
  - fire = 0;
  - shooter_col = 0;
  - shooter_row = 0;
  - attempt counter = 0.
REQ-028 Reset SHALL take priority over enable; reset asserted in any state, including HOLD mid-operation, gives WAIT on the next cycle with no fire.

Configuration
REQ-029 Macro ENEMY_FIRE_SPEEDUP_EN defined: the WAIT threshold is PERIOD/2 (integer) whenever popcount(alive) <= (ROWS*COLUMNS)/4, evaluated at each WAIT cycle.
REQ-030 Macro ENEMY_FIRE_SPEEDUP_EN undefined: the threshold is always PERIOD and no popcount logic is synthesized.

Verification (COLUMNS=13, ROWS=5, PERIOD=16, SEED=16'hACE1 unless stated)
REQ-031 All 65 alive, shot_busy=0, enable=1 after reset -> first fire exactly 16+1+1 cycles after reset release, with shooter_row=4 and shooter_col = (lfsr[3:0] at PICK) reduced per REQ-016.
REQ-032 Only bit 2*13+7=33 alive -> every fire reports col=7, row=2; fires are spaced by PERIOD plus scan cycles.
REQ-033 alive all zero -> fire never asserts over 1000 cycles, and the FSM re-enters WAIT after each 65-cycle scan.
REQ-034 shot_busy=1 when FIRE is reached -> no fire; then:
  - shot_busy released 5 cycles later with the target alive -> fire 2 cycles after release;
  - target killed during HOLD -> a new PICK instead.
REQ-035 enable dropped for 20 cycles mid-WAIT -> the counter and LFSR are frozen and fire stays 0; the next fire is delayed by exactly 20 cycles versus the undisturbed run.
REQ-036 With ENEMY_FIRE_SPEEDUP_EN defined and 16 enemies alive -> WAIT lasts 8 cycles; with 17 alive -> WAIT lasts 16 cycles.
